// File: rtl/umi_addr_remap.sv
// UMI request-path address remapper: rewrites the destination chip-ID field via a
// lookup table or adds an offset inside an address window, behind one output register.

module umi_addr_remap_entry #(
  parameter int IDW = 16
) (
  input  logic [IDW-1:0] i_id,
  input  logic [IDW-1:0] i_old,
  output logic           o_hit
);
  assign o_hit = (i_id == i_old);
endmodule

module umi_addr_remap #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 128,
  parameter int IDW   = 16,
  parameter int IDSB  = 40,
  parameter int NMAPS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDW-1:0]       chipid,
  input  logic [IDW*NMAPS-1:0] old_row_col_address,
  input  logic [IDW*NMAPS-1:0] new_row_col_address,
  input  logic [AW-1:0]        set_dstaddress_offset,
  input  logic [AW-1:0]        set_dstaddress_low,
  input  logic [AW-1:0]        set_dstaddress_high,
  input  logic                 umi_in_valid,
  output logic                 umi_in_ready,
  input  logic [CW-1:0]        umi_in_cmd,
  input  logic [AW-1:0]        umi_in_dstaddr,
  input  logic [AW-1:0]        umi_in_srcaddr,
  input  logic [DW-1:0]        umi_in_data,
  output logic                 umi_out_valid,
  input  logic                 umi_out_ready,
  output logic [CW-1:0]        umi_out_cmd,
  output logic [AW-1:0]        umi_out_dstaddr,
  output logic [AW-1:0]        umi_out_srcaddr,
  output logic [DW-1:0]        umi_out_data
);

  logic [IDW-1:0]   w_id;
  logic [IDW-1:0]   w_new_id;
  logic [NMAPS-1:0] w_hit;
  logic             w_local;
  logic             w_in_win;
  logic             w_acc;
  logic [AW-1:0]    w_dst;

  logic             r_valid;
  logic [CW-1:0]    r_cmd;
  logic [AW-1:0]    r_dst;
  logic [AW-1:0]    r_src;
  logic [DW-1:0]    r_data;

  assign w_id     = umi_in_dstaddr[IDSB+IDW-1:IDSB];
  assign w_local  = (w_id == chipid);
  assign w_in_win = (umi_in_dstaddr >= set_dstaddress_low) &&
                    (umi_in_dstaddr <= set_dstaddress_high);

  genvar g;
  generate
    for (g = 0; g < NMAPS; g++) begin : g_entry
      umi_addr_remap_entry #(.IDW(IDW)) u_entry (
        .i_id  (w_id),
        .i_old (old_row_col_address[g*IDW +: IDW]),
        .o_hit (w_hit[g])
      );
    end
  endgenerate

  // Walk from the top so the lowest matching index overwrites last; no hit keeps the ID.
  always_comb begin
    w_new_id = w_id;
    for (int i = NMAPS-1; i >= 0; i--) begin
      if (w_hit[i]) w_new_id = new_row_col_address[i*IDW +: IDW];
    end
  end

  always_comb begin
    w_dst = umi_in_dstaddr;
    if (w_local)       w_dst = umi_in_dstaddr;
    else if (w_in_win) w_dst = umi_in_dstaddr + set_dstaddress_offset;
    else               w_dst[IDSB+IDW-1:IDSB] = w_new_id;
  end

  // Ready is forced high during reset even if a stalled beat is about to be dropped.
  assign umi_in_ready = reset | ~r_valid | umi_out_ready;
  assign w_acc        = umi_in_valid & umi_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_dst   <= '0;
      r_src   <= '0;
      r_data  <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_cmd   <= umi_in_cmd;
      r_dst   <= w_dst;
      r_src   <= umi_in_srcaddr;
      r_data  <= umi_in_data;
    end else if (umi_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign umi_out_valid   = r_valid;
  assign umi_out_cmd     = r_cmd;
  assign umi_out_dstaddr = r_dst;
  assign umi_out_srcaddr = r_src;
  assign umi_out_data    = r_data;

endmodule

// File: tb/tb_umi_addr_remap.sv
// Directed and randomized checks of umi_addr_remap against an arithmetic reference model.

module tb_umi_addr_remap;
  localparam int CW = 32, AW = 64, DW = 128, IDW = 16, IDSB = 40, NMAPS = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [IDW-1:0]       chipid;
  logic [IDW*NMAPS-1:0] old_rc, new_rc;
  logic [AW-1:0]        off, lo, hi;
  logic                 in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]        in_cmd, out_cmd;
  logic [AW-1:0]        in_dst, in_src, out_dst, out_src;
  logic [DW-1:0]        in_data, out_data;

  umi_addr_remap #(.CW(CW), .AW(AW), .DW(DW), .IDW(IDW), .IDSB(IDSB), .NMAPS(NMAPS)) dut (
    .clk(clk), .reset(reset), .chipid(chipid),
    .old_row_col_address(old_rc), .new_row_col_address(new_rc),
    .set_dstaddress_offset(off), .set_dstaddress_low(lo), .set_dstaddress_high(hi),
    .umi_in_valid(in_valid), .umi_in_ready(in_ready),
    .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst), .umi_in_srcaddr(in_src), .umi_in_data(in_data),
    .umi_out_valid(out_valid), .umi_out_ready(out_ready),
    .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst), .umi_out_srcaddr(out_src), .umi_out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } txn_t;

  int            total = 0, bad = 0;
  logic [IDW-1:0] old_tbl [NMAPS];
  logic [IDW-1:0] new_tbl [NMAPS];
  txn_t          q[$];
  txn_t          e, held;
  logic [AW-1:0] b2b_exp [5];
  logic [AW-1:0] d, a_exp;
  logic [DW-1:0] a_data;
  int            acc, cyc;
  bit            stalled_prev;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_tbl();
    for (int i = 0; i < NMAPS; i++) begin
      old_rc[i*IDW +: IDW] = old_tbl[i];
      new_rc[i*IDW +: IDW] = new_tbl[i];
    end
  endtask

  // Reference: pull the ID out with shifts, swap it in by subtract/add on the whole address.
  function automatic logic [AW-1:0] model(input logic [AW-1:0] a);
    longint unsigned id;
    id = (a >> IDSB) & 64'hFFFF;
    if (id == longint'(chipid)) return a;
    if (a >= lo && a <= hi) return a + off;
    for (int i = 0; i < NMAPS; i++)
      if (id == longint'(old_tbl[i]))
        return a - (64'(id) << IDSB) + (64'(new_tbl[i]) << IDSB);
    return a;
  endfunction

  task automatic rand_payload();
    in_cmd  = $urandom;
    in_src  = {$urandom, $urandom};
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_dst(output logic [AW-1:0] r);
    logic [AW-1:0] edges [4];
    edges[0] = lo; edges[1] = hi; edges[2] = lo - 1; edges[3] = hi + 1;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: r[IDSB+IDW-1:IDSB] = chipid;
      1: r[IDSB+IDW-1:IDSB] = 16'($urandom_range(0, 9));
      2: r = lo + ({$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFF);
      3: r = edges[$urandom_range(0, 3)];
      default: ;
    endcase
  endtask

  // One isolated transfer with out_ready high; checks 1-cycle latency and pass-through fields.
  task automatic send_one(input string tag, input logic [AW-1:0] dst, input logic [AW-1:0] exp);
    rand_payload();
    in_dst = dst; in_valid = 1'b1;
    #1 check({tag, "_pre"}, 128'(out_valid), 128'(1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_vld"}, 128'(out_valid), 128'(1'b1));
    check({tag, "_dst"}, 128'(out_dst), 128'(exp));
    check({tag, "_src"}, 128'(out_src), 128'(in_src));
    check({tag, "_cmd"}, 128'(out_cmd), 128'(in_cmd));
    check({tag, "_dat"}, out_data, in_data);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_cmd = '0; in_dst = '0; in_src = '0; in_data = '0;
    chipid = 16'h0004; off = '0; lo = '0; hi = '0;
    for (int i = 0; i < NMAPS; i++) begin
      old_tbl[i] = 16'(i);
      new_tbl[i] = ~16'(i);
    end
    apply_tbl();
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 128'(out_valid), 128'(1'b0));
    check("rst_dst", 128'(out_dst), 128'(0));
    check("rst_dat", out_data, 128'(0));
    check("rst_rdy", 128'(in_ready), 128'(1'b1));
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // ID field sits at [55:40]
    send_one("remap3", 64'h0000_0300_0000_1000, 64'h00FF_FC00_0000_1000);
    send_one("local",  64'h1200_0400_0000_0080, 64'h1200_0400_0000_0080);
    send_one("nohit",  64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000);
    lo = 64'h0000_0500_0000_0000; hi = 64'h0000_05FF_FFFF_FFFF; off = 64'h0000_0100_0000_0000;
    send_one("win",    64'h0000_0500_0000_0040, 64'h0000_0600_0000_0040);
    send_one("winout", 64'h0000_0600_0000_0000, 64'h00FF_F900_0000_0000);

    // Back-to-back: one output per cycle
    for (int k = 0; k < 5; k++) begin
      rand_dst(d); rand_payload();
      in_dst = d; in_valid = 1'b1; b2b_exp[k] = model(d);
      @(posedge clk); #1;
      check("b2b_vld", 128'(out_valid), 128'(1'b1));
      check("b2b_dst", 128'(out_dst), 128'(b2b_exp[k]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Stall: held beat stays put, ready drops, then drain+accept without a bubble
    out_ready = 1'b0;
    rand_payload(); in_dst = 64'h0000_0200_0000_0010; in_valid = 1'b1;
    a_exp = 64'h00FF_FD00_0000_0010; a_data = in_data;
    #1 check("stall_rdy0", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    rand_payload(); in_dst = 64'h0000_0700_0000_0020;
    #1 check("stall_rdy1", 128'(in_ready), 128'(1'b0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("stall_vld", 128'(out_valid), 128'(1'b1));
      check("stall_dst", 128'(out_dst), 128'(a_exp));
      check("stall_dat", out_data, a_data);
    end
    out_ready = 1'b1;
    #1 check("stall_rdy2", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("nobub_vld", 128'(out_valid), 128'(1'b1));
    check("nobub_dst", 128'(out_dst), 128'(64'h00FF_F800_0000_0020));
    @(posedge clk); #1;
    check("drain_vld", 128'(out_valid), 128'(1'b0));

    // Reset while stalled drops the held beat and ignores input
    out_ready = 1'b0;
    rand_payload(); in_dst = 64'h0000_0100_0000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_vld", 128'(out_valid), 128'(1'b1));
    reset = 1'b1; rand_payload(); in_dst = 64'h0000_0300_0000_0000;
    #1 check("rst_rdy_hi", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    check("mrst_vld", 128'(out_valid), 128'(1'b0));
    check("mrst_dst", 128'(out_dst), 128'(0));
    check("mrst_src", 128'(out_src), 128'(0));
    check("mrst_cmd", 128'(out_cmd), 128'(0));
    check("mrst_dat", out_data, 128'(0));
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_vld", 128'(out_valid), 128'(1'b0));
    send_one("post_rst", 64'h0000_0300_0000_1000, 64'h00FF_FC00_0000_1000);

    // Random traffic with a randomized (possibly duplicated) table
    for (int i = 0; i < NMAPS; i++) begin
      old_tbl[i] = 16'($urandom_range(0, 7));
      new_tbl[i] = 16'($urandom);
    end
    apply_tbl();
    acc = 0; cyc = 0; stalled_prev = 1'b0;
    while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
      cyc++;
      if (stalled_prev) begin
        check("hold_vld", 128'(out_valid), 128'(1'b1));
        check("hold_dst", 128'(out_dst), 128'(held.dst));
        check("hold_dat", out_data, held.data);
      end
      in_valid = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      rand_dst(d); rand_payload(); in_dst = d;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_extra", 128'(out_valid), 128'(1'b0));
        end else begin
          e = q.pop_front();
          check("rnd_dst", 128'(out_dst), 128'(e.dst));
          check("rnd_src", 128'(out_src), 128'(e.src));
          check("rnd_cmd", 128'(out_cmd), 128'(e.cmd));
          check("rnd_dat", out_data, e.data);
        end
      end
      if (in_valid && in_ready) begin
        e.cmd = in_cmd; e.dst = model(in_dst); e.src = in_src; e.data = in_data;
        q.push_back(e);
        acc++;
      end
      stalled_prev = out_valid && !out_ready;
      held.dst = out_dst; held.data = out_data;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rnd_count", 128'(acc), 128'(1000));
    check("rnd_left", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
